// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_I  = 2'd1,
        FILL_D  = 2'd2,
        WRITE_D = 2'd3
    } arb_state_e;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned MEM_LATENCY = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the memory arbiter.
// master: the arbiter itself; slave: the caches and main memory around it.
interface mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        done_i;
    logic        done_d;
    logic        busy;

    modport master (
        input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               fill_we_i, fill_we_d, done_i, done_d, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               fill_we_i, fill_we_d, done_i, done_d, busy
    );

endinterface

// File: rtl/mem_arb_fill_seq.sv
// Block-fill sequencer: issue/receive word counters and last-issue flag.
module mem_arb_fill_seq
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       active,
    input  logic       mem_valid,
    output logic       issue_en,
    output logic [2:0] issue_cnt,
    output logic       rx_fire,
    output logic [2:0] rx_cnt,
    output logic       last_rx
);

    logic [2:0] issue_cnt_q, issue_cnt_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic       last_issue_q, last_issue_d;

    // Issue one read per cycle until the block is requested; accept returns
    // only once the first read can have come back, so stale returns from an
    // aborted fill arriving early in a new fill are dropped.
    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        last_issue_d = last_issue_q;
        issue_en     = active && !last_issue_q;
        rx_fire      = active && mem_valid &&
                       (last_issue_q || ({1'b0, issue_cnt_q} >= 4'(MEM_LATENCY)));
        last_rx      = rx_fire && (rx_cnt_q == 3'(BLOCK_WORDS - 1));
        if (start) begin
            issue_cnt_d  = '0;
            rx_cnt_d     = '0;
            last_issue_d = 1'b0;
        end else begin
            if (issue_en) begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                if (issue_cnt_q == 3'(BLOCK_WORDS - 1)) begin
                    last_issue_d = 1'b1;
                end
            end
            if (rx_fire) begin
                rx_cnt_d = rx_cnt_q + 3'd1;
            end
            if (last_rx) begin
                last_issue_d = 1'b0;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            rx_cnt_q     <= '0;
            last_issue_q <= 1'b0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            last_issue_q <= last_issue_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign rx_cnt    = rx_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between I-cache and D-cache misses for a single main-memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests
// (fixed D priority when undefined).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_e  state_q, state_d;
    logic [11:0] blk_q, blk_d;
    logic        start_fill;
    logic        fill_active;
    logic        grant_d;
    logic        issue_en;
    logic        rx_fire;
    logic        last_rx;
    logic [2:0]  issue_cnt;
    logic [2:0]  rx_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_d_q, last_d_d;
`endif

    assign fill_active = (state_q == FILL_I) || (state_q == FILL_D);

    mem_arb_fill_seq u_fill_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_fill),
        .active    (fill_active),
        .mem_valid (bus.mem_valid),
        .issue_en  (issue_en),
        .issue_cnt (issue_cnt),
        .rx_fire   (rx_fire),
        .rx_cnt    (rx_cnt),
        .last_rx   (last_rx)
    );

    // D-side grant decision when idle.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
        grant_d = bus.d_req;
`endif
    end

    // Next state, address latch and all bus outputs.
    always_comb begin
        state_d        = state_q;
        blk_d          = blk_q;
        start_fill     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d       = last_d_q;
`endif
        bus.mem_en     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.fill_data  = '0;
        bus.fill_word  = '0;
        bus.fill_we_i  = 1'b0;
        bus.fill_we_d  = 1'b0;
        bus.done_i     = 1'b0;
        bus.done_d     = 1'b0;
        bus.busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                    if (bus.d_wr) begin
                        state_d = WRITE_D;
                    end else begin
                        state_d    = FILL_D;
                        blk_d      = bus.d_addr[15:4];
                        start_fill = 1'b1;
                    end
                end else if (bus.i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d   = 1'b0;
`endif
                    state_d    = FILL_I;
                    blk_d      = bus.i_addr[15:4];
                    start_fill = 1'b1;
                end
            end
            FILL_I, FILL_D: begin
                bus.mem_en = issue_en;
                if (issue_en) begin
                    bus.mem_addr = {blk_q, issue_cnt, 1'b0};
                end
                if (rx_fire) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_word = rx_cnt;
                    bus.fill_we_i = (state_q == FILL_I);
                    bus.fill_we_d = (state_q == FILL_D);
                end
                if (last_rx) begin
                    bus.done_i = (state_q == FILL_I);
                    bus.done_d = (state_q == FILL_D);
                    state_d    = IDLE;
                end
            end
            WRITE_D: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.done_d    = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched block address and last-grant registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            blk_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [63:0] mem_q[$];
    logic [63:0] fill_q[$];
    logic [63:0] done_q[$];
    logic [3:0]  v_pipe = '0;
    logic [15:0] a_pipe [4] = '{default: '0};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Memory: a read issued in cycle k returns in cycle k+4.
    always @(posedge clk) begin
        v_pipe    <= {v_pipe[2:0], (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0)};
        a_pipe[0] <= bus.mem_addr;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        a_pipe[3] <= a_pipe[2];
    end
    assign bus.mem_valid = v_pipe[3];
    assign bus.mem_rdata = rd_word(a_pipe[3]);

    function automatic logic [63:0] pack_mem(input logic wr, input logic [15:0] a,
                                             input logic [15:0] wd, input int c);
        return {15'b0, wr, a, wd, c[15:0]};
    endfunction

    function automatic logic [63:0] pack_fill(input logic we_d, input logic we_i,
                                              input logic [2:0] w, input logic [15:0] d,
                                              input int c);
        return {27'b0, we_d, we_i, w, d, c[15:0]};
    endfunction

    function automatic logic [63:0] pack_done(input logic dd, input logic di, input int c);
        return {46'b0, dd, di, c[15:0]};
    endfunction

    function automatic logic [63:0] outs();
        return {6'b0, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
                bus.fill_word, bus.fill_we_i, bus.fill_we_d, bus.done_i, bus.done_d, bus.busy};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input bit is_d);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = is_d ? (bus.done_d === 1'b1) : (bus.done_i === 1'b1);
        end
        if (!seen) check(is_d ? "done_d_timeout" : "done_i_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input bit is_d, input logic [15:0] a, input int g,
                             input int n_iss, input int n_rx, input bit with_done);
        logic [15:0] wa;
        for (int k = 0; k < n_iss; k++) begin
            wa = (a & 16'hFFF0) | 16'(2 * k);
            mem_q.push_back(pack_mem(1'b0, wa, 16'h0, g + 1 + k));
        end
        for (int k = 0; k < n_rx; k++) begin
            wa = (a & 16'hFFF0) | 16'(2 * k);
            fill_q.push_back(pack_fill(is_d, !is_d, 3'(k), rd_word(wa), g + 5 + k));
        end
        if (with_done) done_q.push_back(pack_done(is_d, !is_d, g + 12));
    endtask

    task automatic run_collision(input logic [15:0] ia, input logic [15:0] da, input bit d_first);
        int g = cyc;
        bus.i_addr = ia;
        bus.d_addr = da;
        bus.d_wr   = 1'b0;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        push_fill(d_first, d_first ? da : ia, g, 8, 8, 1'b1);
        push_fill(!d_first, d_first ? ia : da, g + 13, 8, 8, 1'b1);
        wait_done(d_first);
        if (d_first) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
        wait_done(!d_first);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    // Scoreboard: every memory strobe, fill write and done pulse is matched
    // in order against what the stimulus predicted, including its cycle.
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (mem_q.size() == 0) check("mem_unexpected", 64'(mem_q.size()), 64'd1);
            else check("mem_access", pack_mem(bus.mem_wr, bus.mem_addr, bus.mem_wdata, cyc),
                       mem_q.pop_front());
        end
        if (bus.fill_we_i === 1'b1 || bus.fill_we_d === 1'b1) begin
            if (fill_q.size() == 0) check("fill_unexpected", 64'(fill_q.size()), 64'd1);
            else check("fill_word", pack_fill(bus.fill_we_d, bus.fill_we_i, bus.fill_word,
                                              bus.fill_data, cyc), fill_q.pop_front());
        end
        if (bus.done_i === 1'b1 || bus.done_d === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(done_q.size()), 64'd1);
            else check("done_pulse", pack_done(bus.done_d, bus.done_i, cyc), done_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_addr  = '0;
        bus.d_wr    = 1'b0;
        bus.d_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        goto_cycle(cyc + 2);

        // Lone I-cache miss at 0x1236.
        g = cyc;
        bus.i_addr = 16'h1236;
        bus.i_req  = 1'b1;
        push_fill(1'b0, 16'h1236, g, 8, 8, 1'b1);
        @(negedge clk);
        check("busy_grant_cycle", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        check("busy_in_fill", {63'b0, bus.busy}, 64'd1);
        wait_done(1'b0);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("busy_after_done", {63'b0, bus.busy}, 64'd0);
        goto_cycle(cyc + 2);

        // Simultaneous misses after an I grant: D is served first.
        run_collision(16'h2222, 16'h0040, 1'b1);
        goto_cycle(cyc + 2);

        // Single-word write-through.
        g = cyc;
        bus.d_addr  = 16'h00A2;
        bus.d_wdata = 16'hBEEF;
        bus.d_wr    = 1'b1;
        bus.d_req   = 1'b1;
        mem_q.push_back(pack_mem(1'b1, 16'h00A2, 16'hBEEF, g + 1));
        done_q.push_back(pack_done(1'b1, 1'b0, g + 1));
        wait_done(1'b1);
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
        goto_cycle(cyc + 2);

        // Collision right after a D grant: round-robin favours I.
        run_collision(16'h7FF8, 16'h0F84, !RR);
        goto_cycle(cyc + 2);

        // I drops mid-fill while D is pending.
        g = cyc;
        bus.i_addr = 16'h3456;
        bus.i_req  = 1'b1;
        push_fill(1'b0, 16'h3456, g, 8, 8, 1'b1);
        goto_cycle(g + 3);
        bus.i_req  = 1'b0;
        bus.d_addr = 16'h0100;
        bus.d_wr   = 1'b0;
        bus.d_req  = 1'b1;
        push_fill(1'b1, 16'h0100, g + 13, 8, 8, 1'b1);
        wait_done(1'b0);
        wait_done(1'b1);
        bus.d_req = 1'b0;
        goto_cycle(cyc + 2);

        // Reset after the third fill word; late returns must be dropped.
        g = cyc;
        bus.i_addr = 16'h5678;
        bus.i_req  = 1'b1;
        push_fill(1'b0, 16'h5678, g, 7, 3, 1'b0);
        goto_cycle(g + 7);
        rst_n = 1'b0;
        goto_cycle(g + 8);
        rst_n     = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        check("abort_outputs", outs(), 64'h0);
        goto_cycle(g + 14);

        check("mem_q_drained", 64'(mem_q.size()), 64'd0);
        check("fill_q_drained", 64'(fill_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: i_req  in  1  I-cache miss, held until done_i.
REQ-004 SHALL have: i_addr  in  16  I-cache miss byte address.
REQ-005 SHALL have: d_req  in  1  D-cache miss or write, held until done_d.
REQ-006 SHALL have: d_addr  in  16  D-cache byte address.
REQ-007 SHALL have: d_wr  in  1  1 = single-word write-through, 0 = block fill.
REQ-008 SHALL have: d_wdata  in  16  write data.
REQ-009 SHALL have: mem_en, mem_wr  out  1 each  main-memory strobe and write select.
REQ-010 SHALL have: mem_addr, mem_wdata  out  16 each  memory address and write data.
REQ-011 SHALL have: mem_rdata  in  16, mem_valid  in  1  read data and its valid.
REQ-012 SHALL have: fill_data  out  16, fill_word  out  3  returned word and its index in the block.
REQ-013 SHALL have: fill_we_i, fill_we_d  out  1 each  per-cache fill write enable.
REQ-014 SHALL have: done_i, done_d  out  1 each  one-cycle completion pulse.
REQ-015 SHALL have: busy  out  1  high in any non-IDLE state.

Function
REQ-016 SHALL implement FSM states IDLE, FILL_I, FILL_D, WRITE_D.
- IDLE: d_req&d_wr -> WRITE_D; d_req&~d_wr -> FILL_D; i_req only -> FILL_I.
- Both requests in IDLE: D wins (fixed priority).
REQ-017 SHALL latch the requester's address in the IDLE->FILL transition; later input changes are ignored.
REQ-018 SHALL issue fill reads on 8 consecutive cycles starting the cycle after entry.
- mem_addr = {addr[15:4], issue_cnt[2:0], 1'b0}; mem_en=1, mem_wr=0.
REQ-019 SHALL rely on fixed read latency: mem_valid asserts 4 cycles after each issue; one word per cycle.
REQ-020 SHALL increment a 3-bit receive counter on each mem_valid while in FILL.
- Drive fill_data=mem_rdata, fill_word=counter; assert fill_we of the owning cache the same cycle.
- Counter wraps 7->0.
REQ-021 SHALL pulse done_* in the cycle the 8th word is received and return to IDLE next cycle.
- Fill latency: 12 cycles from grant to done.
REQ-022 SHALL, in WRITE_D, drive mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata for one cycle.
- Pulse done_d the same cycle; return to IDLE next cycle.
REQ-023 SHALL ignore mem_valid in IDLE and WRITE_D.
REQ-024 SHALL finish an in-flight fill even if its requester deasserts; the other requester waits.
REQ-025 SHALL allow a new grant in the first IDLE cycle after done; no back-to-back grant in the done cycle.
REQ-026 SHALL drive mem_en, fill_we_*, done_* at 0 whenever not required above.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear both counters and latched address.
- All outputs 0 the following cycle; applies mid-fill.
REQ-028 SHALL discard mem_valid returns belonging to an aborted fill.

Configuration
REQ-029 SHALL support macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous i_req&d_req in IDLE, grant the requester not granted last.
- Last-grant flag resets to I, so D wins first.
- Undefined: fixed D priority per REQ-016.

Structure
REQ-030 SHALL place the state enum, BLOCK_WORDS=8 and MEM_LATENCY=4 in shared package mem_arb_pkg.
REQ-031 SHALL use one sub-module, mem_arb_fill_seq, holding the issue/receive counters and the last-issue/last-receive flags.

Verification
REQ-032 i_req, i_addr=0x1236 alone -> reads 0x1230..0x123E, 8 fill_we_i pulses with fill_word 0..7, done_i 12 cycles after grant.
REQ-033 i_req and d_req(fill, 0x0040) same cycle -> FILL_D first (0x0040..0x004E), then FILL_I; with MEM_ARB_ROUND_ROBIN_EN a second collision grants I.
REQ-034 d_req, d_wr=1, d_addr=0x00A2, d_wdata=0xBEEF -> one cycle mem_wr=1 addr 0x00A2 data 0xBEEF, done_d the same cycle.
REQ-035 rst_n=0 after the 3rd fill word -> IDLE next cycle, outputs 0, late mem_valid produces no fill_we.
REQ-036 i_req dropped mid-fill while d_req pending -> I fill completes all 8 words, then D is granted on the next IDLE cycle.
